// File: rtl/cpu_pkg.sv
// Shared types and helpers for the 8-bit CPU datapath.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int RAM_DEPTH = 2 ** ADDR_W;

    // Control word in decoder bit order: hlt is the MSB, j the LSB.
    typedef struct packed {
        logic hlt;
        logic mi;
        logic ri;
        logic ro;
        logic io;
        logic ii;
        logic ai;
        logic ao;
        logic sumo;
        logic sub;
        logic bi;
        logic oi;
        logic ce;
        logic co;
        logic j;
    } ctrl_t;

    // Returns {carry, result}. For subtract, carry=1 means no borrow.
    function automatic logic [DATA_W:0] alu_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              sub);
        logic [DATA_W-1:0] b_op;
        b_op = sub ? ~b : b;
        return {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
    endfunction

endpackage

// File: rtl/cpu_datapath_ram.sv
// ram16x8: program/data store with one write port and one read port.
// Latency: read is combinational; a write commits on the posedge of clk.
// Backpressure: none; the write is accepted on every edge where we is high.
// Ports: clk; we/waddr/wdata write port (source chosen by the parent);
//        raddr/rdata asynchronous read port.
module ram16x8
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents survive reset on purpose: a program loaded before reset stays.
    logic [DATA_W-1:0] mem_q [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, MAR, RAM, IR, A, B, ALU, flags and output register on one shared bus.
// Latency: enabled registers load the pre-edge bus value on the same posedge; out_valid follows oi by one cycle.
// Backpressure: none; hlt and prog_mode freeze all state (prog_mode still writes RAM through the prog port).
// Ports: clk/rst (async, active-low); 15 decoder control lines; prog_* RAM loader;
//        insn/cf/zf back to the decoder; out_value/out_valid; pc_q/a_q debug; bus_conflict sticky error.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              mi,
    input  logic              ri,
    input  logic              ro,
    input  logic              io,
    input  logic              ii,
    input  logic              ai,
    input  logic              ao,
    input  logic              sumo,
    input  logic              sub,
    input  logic              bi,
    input  logic              oi,
    input  logic              ce,
    input  logic              co,
    input  logic              j,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] insn,
    output logic              cf,
    output logic              zf,
    output logic [DATA_W-1:0] out_value,
    output logic              out_valid,
    output logic [ADDR_W-1:0] pc_q,
    output logic [DATA_W-1:0] a_q,
    output logic              bus_conflict
);

    ctrl_t ctrl;
    assign ctrl = '{hlt: hlt, mi: mi, ri: ri, ro: ro, io: io, ii: ii, ai: ai,
                    ao: ao, sumo: sumo, sub: sub, bi: bi, oi: oi, ce: ce,
                    co: co, j: j};

    logic [ADDR_W-1:0] pc_d,  mar_q, mar_d;
    logic [DATA_W-1:0] ir_q,  ir_d,  a_d,  b_q, b_d, out_value_q, out_value_d;
    logic              cf_q,  cf_d,  zf_q, zf_d;
    logic              out_valid_q, out_valid_d, bus_conflict_q, bus_conflict_d;

    logic [DATA_W-1:0] bus, ram_rdata;
    logic [DATA_W:0]   alu;
    logic [2:0]        n_drv;
    logic              run;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign run = !prog_mode && !ctrl.hlt;
    assign alu = alu_add(a_q, b_q, ctrl.sub);

    // Priority mux keeps the bus defined even when drivers collide.
    always_comb begin
        bus = '0;
        if (ctrl.co)        bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
        else if (ctrl.ro)   bus = ram_rdata;
        else if (ctrl.io)   bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
        else if (ctrl.ao)   bus = a_q;
        else if (ctrl.sumo) bus = alu[DATA_W-1:0];
    end

    assign n_drv = {2'b0, ctrl.co} + {2'b0, ctrl.ro} + {2'b0, ctrl.io}
                 + {2'b0, ctrl.ao} + {2'b0, ctrl.sumo};

    // RAM write source: prog port while programming, else the bus at the
    // current (pre-edge) MAR.
    assign ram_we    = prog_mode ? prog_we   : (run && ctrl.ri);
    assign ram_waddr = prog_mode ? prog_addr : mar_q;
    assign ram_wdata = prog_mode ? prog_data : bus;

    ram16x8 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (mar_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        pc_d           = pc_q;
        mar_d          = mar_q;
        ir_d           = ir_q;
        a_d            = a_q;
        b_d            = b_q;
        out_value_d    = out_value_q;
        cf_d           = cf_q;
        zf_d           = zf_q;
        out_valid_d    = 1'b0;
        bus_conflict_d = bus_conflict_q;
        if (run) begin
            if (ctrl.mi) mar_d       = bus[ADDR_W-1:0];
            if (ctrl.ii) ir_d        = bus;
            if (ctrl.ai) a_d         = bus;
            if (ctrl.bi) b_d         = bus;
            if (ctrl.oi) out_value_d = bus;
            out_valid_d = ctrl.oi;
            if (ctrl.j)       pc_d = bus[ADDR_W-1:0];
            else if (ctrl.ce) pc_d = pc_q + 1'b1;
            if (ctrl.sumo) begin
                cf_d = alu[DATA_W];
                zf_d = (alu[DATA_W-1:0] == '0);
            end
            if (n_drv > 3'd1) bus_conflict_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q           <= '0;
            mar_q          <= '0;
            ir_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            out_value_q    <= '0;
            cf_q           <= 1'b0;
            zf_q           <= 1'b0;
            out_valid_q    <= 1'b0;
            bus_conflict_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            mar_q          <= mar_d;
            ir_q           <= ir_d;
            a_q            <= a_d;
            b_q            <= b_d;
            out_value_q    <= out_value_d;
            cf_q           <= cf_d;
            zf_q           <= zf_d;
            out_valid_q    <= out_valid_d;
            bus_conflict_q <= bus_conflict_d;
        end
    end

    assign insn         = ir_q;
    assign cf           = cf_q;
    assign zf           = zf_q;
    assign out_value    = out_value_q;
    assign out_valid    = out_valid_q;
    assign bus_conflict = bus_conflict_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed testbench for cpu_datapath.
// Latency: checks are sampled 1ns after each posedge.
// Backpressure: n/a.
module tb_cpu_datapath;
    import cpu_pkg::*;

    // Control masks in decoder bit order (hlt = bit 14 ... j = bit 0).
    localparam logic [14:0] C_HLT  = 15'h4000, C_MI = 15'h2000, C_RI = 15'h1000,
                            C_RO   = 15'h0800, C_IO = 15'h0400, C_II = 15'h0200,
                            C_AI   = 15'h0100, C_AO = 15'h0080, C_SUMO = 15'h0040,
                            C_SUB  = 15'h0020, C_BI = 15'h0010, C_OI = 15'h0008,
                            C_CE   = 15'h0004, C_CO = 15'h0002, C_J  = 15'h0001;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    ctrl_t             ctl = '0;
    logic              prog_mode = 1'b0, prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [DATA_W-1:0] prog_data = '0;
    logic [DATA_W-1:0] insn, out_value, a_q;
    logic [ADDR_W-1:0] pc_q;
    logic              cf, zf, out_valid, bus_conflict;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk(clk), .rst(rst),
        .hlt(ctl.hlt), .mi(ctl.mi), .ri(ctl.ri), .ro(ctl.ro), .io(ctl.io),
        .ii(ctl.ii), .ai(ctl.ai), .ao(ctl.ao), .sumo(ctl.sumo), .sub(ctl.sub),
        .bi(ctl.bi), .oi(ctl.oi), .ce(ctl.ce), .co(ctl.co), .j(ctl.j),
        .prog_mode(prog_mode), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .insn(insn), .cf(cf), .zf(zf),
        .out_value(out_value), .out_valid(out_valid), .pc_q(pc_q), .a_q(a_q),
        .bus_conflict(bus_conflict)
    );

    // One run-mode microstep: controls change on negedge, capture on posedge.
    task automatic step(input logic [14:0] c);
        @(negedge clk);
        prog_mode = 1'b0;
        prog_we   = 1'b0;
        ctl       = ctrl_t'(c);
        @(posedge clk);
        #1;
    endtask

    // One programming-mode RAM write; c is driven on the control lines to
    // show they are ignored while programming.
    task automatic prog_wr(input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data,
                           input logic [14:0]       c);
        @(negedge clk);
        prog_mode = 1'b1;
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        ctl       = ctrl_t'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        ctl = '0;
        prog_mode = 1'b0;
        prog_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({pc_q, a_q, insn, out_value, cf, zf, out_valid, bus_conflict} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h a=%h insn=%h out=%h cf=%b zf=%b ov=%b bc=%b, want all 0",
                     pc_q, a_q, insn, out_value, cf, zf, out_valid, bus_conflict);
        end
    endtask

    task automatic test_reset_mid_op();
        // mar is 0 after reset
        prog_wr(4'd0, 8'h55, '0);
        step(C_RO | C_AI);
        prog_wr(4'd3, 8'hAA, '0);
        prog_wr(4'd0, 8'hFF, '0);
        step(C_RO | C_BI);
        step(C_CE);
        step(C_AO | C_OI);
        step(C_SUMO);                  // 0x55 + 0xFF = 0x154 -> cf=1, zf=0
        n_tests++;
        if (pc_q !== 4'd1 || a_q !== 8'h55 || out_value !== 8'h55 || cf !== 1'b1 || zf !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_state: got pc=%h a=%h out=%h cf=%b zf=%b, want 1 55 55 1 0",
                     pc_q, a_q, out_value, cf, zf);
        end
        #2 rst = 1'b0;                 // between edges
        #1;
        n_tests++;
        if (pc_q !== 4'd0 || a_q !== 8'h00 || out_value !== 8'h00 || cf !== 1'b0 || zf !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got pc=%h a=%h out=%h cf=%b zf=%b, want all 0",
                     pc_q, a_q, out_value, cf, zf);
        end
        @(negedge clk);
        rst = 1'b1;
        // read back ram[3]: mar <- 3 through ram[0], then A <- ram[3]
        prog_wr(4'd0, 8'h03, '0);
        step(C_RO | C_MI);
        step(C_RO | C_AI);
        n_tests++;
        if (a_q !== 8'hAA) begin
            n_fail++;
            $display("FAIL ram_survives_reset: got a=%h, want aa", a_q);
        end
    endtask

    task automatic test_program_fetch();
        pulse_reset();
        prog_wr(4'd0,  8'h1E, C_CE | C_AI);
        prog_wr(4'd14, 8'h1C, C_CO | C_AO);
        n_tests++;
        if (pc_q !== 4'd0 || a_q !== 8'h00 || bus_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL prog_mode_ignores_ctrl: got pc=%h a=%h bc=%b, want 0 00 0", pc_q, a_q, bus_conflict);
        end
        step(C_CO | C_MI);
        step(C_RO | C_II | C_CE);
        step(C_IO | C_MI);
        step(C_RO | C_AI);
        n_tests++;
        if (insn !== 8'h1E || pc_q !== 4'd1 || a_q !== 8'h1C || bus_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch: got insn=%h pc=%h a=%h bc=%b, want 1e 1 1c 0",
                     insn, pc_q, a_q, bus_conflict);
        end
    endtask

    // mar is 14 from here on
    task automatic test_add_overflow();
        prog_wr(4'd14, 8'hF0, '0);
        step(C_RO | C_AI);
        prog_wr(4'd14, 8'h20, '0);
        step(C_RO | C_BI);
        step(C_SUMO | C_AI);
        n_tests++;
        if (a_q !== 8'h10 || cf !== 1'b1 || zf !== 1'b0) begin
            n_fail++;
            $display("FAIL add_overflow: got a=%h cf=%b zf=%b, want 10 1 0", a_q, cf, zf);
        end
    endtask

    task automatic test_sub_equal();
        prog_wr(4'd14, 8'h07, '0);
        step(C_RO | C_AI);
        step(C_RO | C_BI);
        step(C_SUMO | C_SUB | C_AI);
        n_tests++;
        if (a_q !== 8'h00 || cf !== 1'b1 || zf !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_equal: got a=%h cf=%b zf=%b, want 00 1 1", a_q, cf, zf);
        end
        step('0);
        step(C_RO | C_AI);             // A changes, flags must not
        n_tests++;
        if (a_q !== 8'h07 || cf !== 1'b1 || zf !== 1'b1) begin
            n_fail++;
            $display("FAIL flags_hold: got a=%h cf=%b zf=%b, want 07 1 1", a_q, cf, zf);
        end
    endtask

    task automatic test_pc_jump();
        prog_wr(4'd14, 8'h0F, '0);
        step(C_RO | C_J);
        n_tests++;
        if (pc_q !== 4'hF) begin
            n_fail++;
            $display("FAIL jump_to_15: got pc=%h, want f", pc_q);
        end
        step(C_CE);
        n_tests++;
        if (pc_q !== 4'h0) begin
            n_fail++;
            $display("FAIL pc_wrap: got pc=%h, want 0", pc_q);
        end
        prog_wr(4'd14, 8'h69, '0);
        step(C_RO | C_II);
        step(C_IO | C_J | C_CE);
        n_tests++;
        if (insn !== 8'h69 || pc_q !== 4'h9) begin
            n_fail++;
            $display("FAIL jump_priority: got insn=%h pc=%h, want 69 9", insn, pc_q);
        end
        step(C_HLT | C_CE);
        step(C_HLT | C_RO | C_AI);
        step(C_HLT | C_CO | C_AO);
        n_tests++;
        if (pc_q !== 4'h9 || a_q !== 8'h07 || bus_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_freeze: got pc=%h a=%h bc=%b, want 9 07 0", pc_q, a_q, bus_conflict);
        end
    endtask

    task automatic test_output_conflict();
        prog_wr(4'd14, 8'h42, '0);
        step(C_RO | C_AI);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL out_valid_idle: got %b, want 0", out_valid);
        end
        step(C_AO | C_OI);
        n_tests++;
        if (out_value !== 8'h42 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL output_load: got out=%h ov=%b, want 42 1", out_value, out_valid);
        end
        step('0);
        n_tests++;
        if (out_value !== 8'h42 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL out_valid_pulse: got out=%h ov=%b, want 42 0", out_value, out_valid);
        end
        prog_wr(4'd14, 8'h03, '0);
        step(C_RO | C_J);
        n_tests++;
        if (pc_q !== 4'h3 || bus_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_conflict: got pc=%h bc=%b, want 3 0", pc_q, bus_conflict);
        end
        step(C_CO | C_AO | C_OI);      // co wins the bus
        n_tests++;
        if (out_value !== 8'h03 || bus_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict: got out=%h bc=%b, want 03 1", out_value, bus_conflict);
        end
        for (int i = 0; i < 5; i++) step('0);
        n_tests++;
        if (bus_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_sticky: got bc=%b, want 1", bus_conflict);
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_reset_mid_op();
        test_program_fetch();
        test_add_overflow();
        test_sub_equal();
        test_pc_jump();
        test_output_conflict();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
